// File: rtl/score_disp_pkg.sv
// Shared definitions for the score display driver.
//   - Converter FSM state type
//   - Display geometry (NUM_DIGITS, SCORE_W, BCD_W)
//   - Active-high 7-segment glyphs, bit order {g,f,e,d,c,b,a}
//   - dd_adjust: the double-dabble "add 3 to every nibble >= 5" step
package score_disp_pkg;

  localparam int unsigned NUM_DIGITS = 5;
  localparam int unsigned SCORE_W    = 16;
  localparam int unsigned BCD_W      = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } conv_state_t;

  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  // Adds 3 to each BCD nibble that is 5 or more, so the following left
  // shift carries correctly into the next decimal digit.
  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] acc);
    logic [BCD_W-1:0] res;
    res = acc;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational BCD nibble to 7-segment glyph decoder.
//   nibble  in   4  BCD digit (0..9); any other value decodes to blank
//   glyph   out  7  active-high segments {g,f,e,d,c,b,a}
// Output polarity for the board is applied by the instantiating module.
module seven_seg_decoder
  import score_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = GLYPH_BLANK;
    unique case (nibble)
      4'd0:    glyph = GLYPH_0;
      4'd1:    glyph = GLYPH_1;
      4'd2:    glyph = GLYPH_2;
      4'd3:    glyph = GLYPH_3;
      4'd4:    glyph = GLYPH_4;
      4'd5:    glyph = GLYPH_5;
      4'd6:    glyph = GLYPH_6;
      4'd7:    glyph = GLYPH_7;
      4'd8:    glyph = GLYPH_8;
      4'd9:    glyph = GLYPH_9;
      default: glyph = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/score_display_driver.sv
// Score display driver: converts the 16-bit binary score to 5-digit BCD with
// a sequential double-dabble converter (one bit per clock) and scans the
// committed BCD value onto a multiplexed 7-segment display.
//   clk        in   1   system clock
//   reset      in   1   asynchronous, active-high reset
//   score      in   16  binary score, may change on any cycle
//   bcd        out  20  committed BCD value, [3:0] = units
//   bcd_valid  out  1   one-cycle pulse when bcd updates
//   busy       out  1   high while a conversion is in flight
//   an         out  5   digit enables, an[0] = units
//   seg        out  7   segments {g,f,e,d,c,b,a}
// Parameters:
//   SCAN_DIV    clk cycles each digit stays lit (>= 2)
//   BLANK_LZ    1 = blank leading zeros (units digit never blanked)
//   ACTIVE_LOW  1 = an/seg driven active-low (common anode)
module score_display_driver
  import score_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter bit          BLANK_LZ   = 1'b1,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SCORE_W-1:0]   score,
  output logic [BCD_W-1:0]     bcd,
  output logic                 bcd_valid,
  output logic                 busy,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]           seg
);

  localparam int unsigned PS_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  conv_state_t        state;
  logic [SCORE_W-1:0] sh;
  logic [SCORE_W-1:0] captured;
  logic [SCORE_W-1:0] last_score;
  logic [BCD_W-1:0]   acc;
  logic [3:0]         cnt;

  logic [PS_W-1:0]    presc;
  logic [2:0]         digit;

  logic [3:0]              cur_nib;
  logic                    blank;
  logic [6:0]              glyph;
  logic [NUM_DIGITS-1:0]   an_act;
  logic [6:0]              seg_act;

  // Converter FSM. sh is consumed by the shift, so the captured score is held
  // separately to become last_score at commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sh         <= '0;
      captured   <= '0;
      last_score <= '0;
      acc        <= '0;
      cnt        <= '0;
      bcd        <= '0;
      bcd_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (score != last_score) begin
            sh       <= score;
            captured <= score;
            acc      <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          {acc, sh} <= {dd_adjust(acc), sh} << 1;
          cnt       <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          bcd        <= acc;
          last_score <= captured;
          bcd_valid  <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Digit scanner: prescaler wrap advances the digit index 0..NUM_DIGITS-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      digit <= '0;
    end else begin
      if (presc == PS_W'(SCAN_DIV - 1)) begin
        presc <= '0;
        if (digit == 3'(NUM_DIGITS - 1)) begin
          digit <= '0;
        end else begin
          digit <= digit + 3'd1;
        end
      end else begin
        presc <= presc + PS_W'(1);
      end
    end
  end

  // Digit select, one-hot enable and leading-zero blanking from committed bcd.
  always_comb begin
    cur_nib = '0;
    an_act  = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (digit == 3'(i)) begin
        cur_nib   = bcd[4*i +: 4];
        an_act[i] = 1'b1;
      end
    end
    // Digit i is a leading zero when it and every digit above it are zero.
    blank = BLANK_LZ && (digit != 3'd0) && ((bcd >> {digit, 2'b00}) == '0);
  end

  seven_seg_decoder u_dec (
    .nibble (cur_nib),
    .glyph  (glyph)
  );

  assign seg_act = blank ? GLYPH_BLANK : glyph;
  assign an      = ACTIVE_LOW ? ~an_act  : an_act;
  assign seg     = ACTIVE_LOW ? ~seg_act : seg_act;

endmodule

// File: tb/tb_score_display_driver.sv
// Self-checking bench for score_display_driver with SCAN_DIV=4.
// Two instances share clock, reset and score: dut (leading-zero blanking on)
// and dut_nb (blanking off). Expected bcd values are queued when a score is
// driven and popped by a monitor on every dut bcd_valid pulse.
module tb_score_display_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] score;

  logic [19:0] bcd,       bcd_nb;
  logic        bcd_valid, bcd_valid_nb;
  logic        busy,      busy_nb;
  logic [4:0]  an,        an_nb;
  logic [6:0]  seg,       seg_nb;

  int          checks   = 0;
  int          failures = 0;
  logic [19:0] exp_q[$];
  logic [19:0] sb_exp;
  int          scan_n;

  score_display_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b1), .ACTIVE_LOW(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .score     (score),
    .bcd       (bcd),
    .bcd_valid (bcd_valid),
    .busy      (busy),
    .an        (an),
    .seg       (seg)
  );

  score_display_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b0), .ACTIVE_LOW(1'b1)) dut_nb (
    .clk       (clk),
    .reset     (reset),
    .score     (score),
    .bcd       (bcd_nb),
    .bcd_valid (bcd_valid_nb),
    .busy      (busy_nb),
    .an        (an_nb),
    .seg       (seg_nb)
  );

  always #5 clk = ~clk;

  // Scan phase: clock edges seen since reset was released.
  always @(posedge clk or posedge reset) begin
    if (reset) scan_n <= 0;
    else       scan_n <= scan_n + 1;
  end

  // Scoreboard: every bcd_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && bcd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_valid: bcd=%h with no expected value queued", bcd);
      end else begin
        sb_exp = exp_q.pop_front();
        if (bcd !== sb_exp) begin
          failures++;
          $display("FAIL sb_bcd: got %h expected %h", bcd, sb_exp);
        end
      end
    end
  end

  function automatic logic [6:0] glyph_of(input logic [3:0] n);
    case (n)
      4'd0: return 7'b0111111;
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  // Expected active-low seg pins for digit d of value b.
  function automatic logic [6:0] exp_seg(input logic [19:0] b, input int d, input bit lz);
    logic [3:0]  nib;
    logic [19:0] upper;
    nib   = b[4*d +: 4];
    upper = b >> (4*d);
    if (lz && d > 0 && upper == 20'h0) return 7'b1111111;
    return ~glyph_of(nib);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks conversion timing; the score change was driven just before E0.
  task automatic expect_conv(input string name, input logic [19:0] exp);
    tick(); // E0
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_busy_e0: got %b expected 1", name, busy);
    end
    for (int k = 1; k <= 16; k++) begin
      tick();
      checks++;
      if (busy !== 1'b1 || bcd_valid !== 1'b0) begin
        failures++;
        $display("FAIL %s_inflight_e%0d: busy=%b valid=%b expected busy=1 valid=0", name, k, busy, bcd_valid);
      end
    end
    tick(); // E17
    checks++;
    if (bcd_valid !== 1'b1 || bcd !== exp || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_commit_e17: valid=%b bcd=%h busy=%b expected valid=1 bcd=%h busy=0",
               name, bcd_valid, bcd, busy, exp);
    end
  endtask

  // Walks one full scan rotation on both instances.
  task automatic check_scan(input string name, input logic [19:0] b);
    int d;
    for (int n = 0; n < 20; n++) begin
      tick();
      d = (scan_n / 4) % 5;
      checks++;
      if (an !== ~(5'b00001 << d) || seg !== exp_seg(b, d, 1'b1)) begin
        failures++;
        $display("FAIL %s_scan_lz d=%0d: an=%b seg=%b expected an=%b seg=%b",
                 name, d, an, seg, ~(5'b00001 << d), exp_seg(b, d, 1'b1));
      end
      checks++;
      if (an_nb !== ~(5'b00001 << d) || seg_nb !== exp_seg(b, d, 1'b0)) begin
        failures++;
        $display("FAIL %s_scan_nolz d=%0d: an=%b seg=%b expected an=%b seg=%b",
                 name, d, an_nb, seg_nb, ~(5'b00001 << d), exp_seg(b, d, 1'b0));
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    score = 16'd0;
    #23;
    checks++;
    if (bcd !== 20'h0 || busy !== 1'b0 || bcd_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: bcd=%h busy=%b valid=%b expected 0/0/0", bcd, busy, bcd_valid);
    end
    checks++;
    if (an !== 5'b11110 || seg !== 7'b1000000) begin
      failures++;
      $display("FAIL reset_display: an=%b seg=%b expected an=11110 seg=1000000", an, seg);
    end
    tick();
    reset = 1'b0;
    check_scan("reset", 20'h0);
  endtask

  task automatic test_convert_1234();
    score = 16'd1234;
    exp_q.push_back(20'h01234);
    expect_conv("c1234", 20'h01234);
    check_scan("c1234", 20'h01234);
  endtask

  task automatic test_max();
    logic [19:0] b;
    score = 16'd65535;
    exp_q.push_back(20'h65535);
    expect_conv("max", 20'h65535);
    b = bcd;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (b[4*i +: 4] > 4'd9) begin
        failures++;
        $display("FAIL max_nibble%0d: got %h expected <= 9", i, b[4*i +: 4]);
      end
    end
    check_scan("max", 20'h65535);
  endtask

  task automatic test_back_to_back();
    int valids = 0;
    score = 16'd100;
    exp_q.push_back(20'h00100);
    exp_q.push_back(20'h00200);
    tick(); // E0
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bcd_valid === 1'b1) valids++;
      if (k == 5) score = 16'd200;
      if (k == 17) begin
        checks++;
        if (bcd_valid !== 1'b1 || bcd !== 20'h00100) begin
          failures++;
          $display("FAIL b2b_first_e17: valid=%b bcd=%h expected 1/00100", bcd_valid, bcd);
        end
      end
      if (k == 18) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL b2b_redetect_e18: busy=%b expected 1", busy);
        end
      end
      if (k == 35) begin
        checks++;
        if (bcd_valid !== 1'b1 || bcd !== 20'h00200) begin
          failures++;
          $display("FAIL b2b_second_e35: valid=%b bcd=%h expected 1/00200", bcd_valid, bcd);
        end
      end
    end
    checks++;
    if (valids != 2) begin
      failures++;
      $display("FAIL b2b_pulse_count: got %0d expected 2", valids);
    end
  endtask

  task automatic test_reset_mid();
    score = 16'd999;
    exp_q.push_back(20'h00999);
    for (int k = 0; k <= 8; k++) tick(); // through E8
    reset = 1'b1;
    #1;
    checks++;
    if (bcd !== 20'h0 || busy !== 1'b0 || bcd_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_state: bcd=%h busy=%b valid=%b expected 0/0/0", bcd, busy, bcd_valid);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (bcd_valid !== 1'b0 || bcd !== 20'h0) begin
        failures++;
        $display("FAIL midrst_hold: valid=%b bcd=%h expected 0/00000", bcd_valid, bcd);
      end
    end
    reset = 1'b0;
    expect_conv("midrst", 20'h00999);
    check_scan("midrst", 20'h00999);
  endtask

  task automatic test_no_blank();
    score = 16'd7;
    exp_q.push_back(20'h00007);
    expect_conv("nolz", 20'h00007);
    check_scan("nolz", 20'h00007);
  endtask

  initial begin
    test_reset();
    test_convert_1234();
    test_max();
    test_back_to_back();
    test_reset_mid();
    test_no_blank();
    tick();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: %0d expected results never produced", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
